// File: rtl/ifetch_queue_if.sv
// Fetch-unit bundle: redirect input, RAM req/ack port and dispatcher valid/ready port.
// The fetch unit connects through the master modport; the RAM/core side uses slave.
`timescale 1ns/1ps
interface ifetch_queue_if;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic        o_valid;
    logic [15:0] o_ir;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        o_fault;

    modport master (
        input  i_redirect, i_redirect_pc, i_mem_ack, i_mem_data, i_ready,
        output o_mem_req, o_mem_addr, o_valid, o_ir, o_pc, o_fault
    );

    modport slave (
        output i_redirect, i_redirect_pc, i_mem_ack, i_mem_data, i_ready,
        input  o_mem_req, o_mem_addr, o_valid, o_ir, o_pc, o_fault
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: word reads from unified RAM, split into 16-bit instructions,
// prefetch queue to the dispatcher. Macro FETCH_MISALIGN_EN enables the misaligned-target fault.
`timescale 1ns/1ps
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ifetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t        state, state_nx;
    logic [31:0]   fetch_pc, fetch_pc_nx;
    logic [31:0]   mem_addr, mem_addr_nx;
    logic          fault, fault_nx;
    logic [PW:0]   count, count_nx;
    logic [PW:0]   free, need;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [15:0]   ir_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic          ack, pop, push_lo, push_hi;
    logic [31:0]   target;
    logic          bad_target;

`ifdef FETCH_MISALIGN_EN
    assign target     = bus.i_redirect_pc;
    assign bad_target = bus.i_redirect & bus.i_redirect_pc[0];
`else
    assign target     = bus.i_redirect_pc & ~32'h1;
    assign bad_target = 1'b0;
`endif

    assign ack  = bus.i_mem_ack & (state != IDLE);
    assign pop  = (count != '0) & bus.i_ready & ~bus.i_redirect;
    // Free slots counted after this cycle's pop so a request can issue on the same edge.
    assign free = (PW+1)'(DEPTH) - count + (PW+1)'(pop);
    assign need = fetch_pc[1] ? (PW+1)'(1) : (PW+1)'(2);

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        mem_addr_nx = mem_addr;
        fault_nx    = fault | bad_target;
        push_lo     = 1'b0;
        push_hi     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_redirect) begin
                    fetch_pc_nx = target;
                    // Flushed queue always has room, so issue straight to the target.
                    if (!bad_target && !fault) begin
                        state_nx    = REQ;
                        mem_addr_nx = target & ~32'h3;
                    end
                end else if (!fault && free >= need) begin
                    state_nx    = REQ;
                    mem_addr_nx = fetch_pc & ~32'h3;
                end
            end
            REQ: begin
                if (bus.i_redirect) begin
                    fetch_pc_nx = target;
                    state_nx    = ack ? IDLE : DRAIN;
                end else if (ack) begin
                    push_hi     = 1'b1;
                    push_lo     = ~fetch_pc[1];
                    fetch_pc_nx = mem_addr + 32'd4;
                    state_nx    = IDLE;
                end
            end
            DRAIN: begin
                if (bus.i_redirect) fetch_pc_nx = target;
                if (ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        count_nx = count + (PW+1)'(push_lo) + (PW+1)'(push_hi) - (PW+1)'(pop);
        if (bus.i_redirect) count_nx = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= '0;
            fault    <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            mem_addr <= mem_addr_nx;
            fault    <= fault_nx;
            count    <= count_nx;
            if (bus.i_redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr + PW'(pop);
                wr_ptr <= wr_ptr + PW'(push_lo) + PW'(push_hi);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ir_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else begin
            if (push_lo) begin
                ir_q[wr_ptr] <= bus.i_mem_data[15:0];
                pc_q[wr_ptr] <= mem_addr;
            end
            if (push_hi) begin
                ir_q[wr_ptr + PW'(push_lo)] <= bus.i_mem_data[31:16];
                pc_q[wr_ptr + PW'(push_lo)] <= {mem_addr[31:2], 2'b10};
            end
        end
    end

    assign bus.o_mem_req  = (state != IDLE);
    assign bus.o_mem_addr = mem_addr;
    assign bus.o_valid    = (count != '0);
    assign bus.o_ir       = ir_q[rd_ptr];
    assign bus.o_pc       = pc_q[rd_ptr];
    assign bus.o_fault    = fault;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: RAM responder with programmable ack delay and a
// scoreboard of expected {pc, instruction} pairs checked as the dispatcher consumes them.
`timescale 1ns/1ps
module tb_ifetch_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_queue_if bus();

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          ack_delay = 1;
    int          wait_cnt = 0;
    int          req_count = 0;
    logic [47:0] sb [$];

    function automatic logic [15:0] hw(logic [31:0] p);
        case (p)
            32'h0:   return 16'h1111;
            32'h2:   return 16'h2222;
            32'h4:   return 16'h3333;
            32'h6:   return 16'h4444;
            default: return p[15:0] ^ 16'h5A00;
        endcase
    endfunction

    function automatic logic [31:0] ram(logic [31:0] a);
        return {hw(a + 32'd2), hw(a)};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(logic [31:0] pc);
        sb.push_back({pc, hw(pc)});
    endtask

    task automatic wait_drain(string tag, int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check(tag, sb.size(), 0);
    endtask

    // RAM responder: acks after ack_delay cycles of a visible request
    always @(negedge clk) begin
        if (!rst_n || !bus.o_mem_req) begin
            bus.i_mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (bus.i_mem_ack) begin
            bus.i_mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            bus.i_mem_ack  = 1'b1;
            bus.i_mem_data = ram(bus.o_mem_addr);
            req_count++;
            wait_cnt = 0;
        end else begin
            wait_cnt++;
        end
    end

    // Scoreboard: compare every consumed head against the next expected entry
    always @(negedge clk) begin
        #1;
        if (rst_n && bus.o_valid && bus.i_ready && !bus.i_redirect && sb.size() != 0) begin
            logic [47:0] e;
            e = sb.pop_front();
            check("head_pc", bus.o_pc, e[47:16]);
            check("head_ir", {16'h0, bus.o_ir}, {16'h0, e[15:0]});
        end
    end

    initial begin
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_mem_ack     = 1'b0;
        bus.i_mem_data    = '0;
        bus.i_ready       = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", bus.o_valid, 0);
        check("rst_req", bus.o_mem_req, 0);
        check("rst_fault", bus.o_fault, 0);
        check("rst_ir", bus.o_ir, 0);
        check("rst_pc", bus.o_pc, 0);

        // Sequential fetch from reset
        push_exp(32'h0); push_exp(32'h2); push_exp(32'h4); push_exp(32'h6);
        rst_n = 1'b1;
        wait_drain("t1_drain", 40);

        // Backpressure: queue fills with exactly two requests
        rst_n = 1'b0;
        bus.i_ready = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        req_count = 0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t2_reqs", req_count, 2);
        check("t2_req_low", bus.o_mem_req, 0);
        check("t2_valid", bus.o_valid, 1);
        check("t2_head0", bus.o_pc, 32'h0);
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        check("t2_head1", bus.o_pc, 32'h2);
        repeat (6) @(negedge clk);
        check("t2_no_req", req_count, 2);
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("t2_refill", req_count, 3);
        check("t2_head2", bus.o_pc, 32'h4);

        // Redirect to an odd halfword while full and idle
        bus.i_redirect = 1'b1;
        bus.i_redirect_pc = 32'h0000_0102;
        push_exp(32'h102); push_exp(32'h104); push_exp(32'h106); push_exp(32'h108);
        @(negedge clk);
        bus.i_redirect = 1'b0;
        check("t3_valid", bus.o_valid, 0);
        check("t3_req", bus.o_mem_req, 1);
        check("t3_addr", bus.o_mem_addr, 32'h100);
        bus.i_ready = 1'b1;
        wait_drain("t3_drain", 40);

        // Redirect while a slow request is outstanding
        bus.i_ready = 1'b0;
        repeat (15) @(negedge clk);
        ack_delay = 3;
        bus.i_redirect = 1'b1;
        bus.i_redirect_pc = 32'h8;
        @(negedge clk);
        bus.i_redirect = 1'b0;
        check("t4_req8", bus.o_mem_addr, 32'h8);
        @(negedge clk);
        bus.i_redirect = 1'b1;
        bus.i_redirect_pc = 32'h40;
        push_exp(32'h40); push_exp(32'h42); push_exp(32'h44);
        @(negedge clk);
        bus.i_redirect = 1'b0;
        bus.i_ready = 1'b1;
        check("t4_drain_req", bus.o_mem_req, 1);
        check("t4_drain_addr", bus.o_mem_addr, 32'h8);
        check("t4_valid", bus.o_valid, 0);
        for (int i = 0; i < 20; i++) begin
            if (bus.o_mem_req && bus.o_mem_addr != 32'h8) break;
            @(negedge clk);
        end
        check("t4_next_addr", bus.o_mem_addr, 32'h40);
        wait_drain("t4_drain", 60);

        // Address wrap at the top of memory
        ack_delay = 1;
        bus.i_ready = 1'b0;
        repeat (20) @(negedge clk);
        bus.i_redirect = 1'b1;
        bus.i_redirect_pc = 32'hFFFF_FFFC;
        push_exp(32'hFFFF_FFFC); push_exp(32'hFFFF_FFFE); push_exp(32'h0); push_exp(32'h2);
        @(negedge clk);
        bus.i_redirect = 1'b0;
        bus.i_ready = 1'b1;
        check("t5_addr", bus.o_mem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 20; i++) begin
            if (bus.o_mem_req && bus.o_mem_addr != 32'hFFFF_FFFC) break;
            @(negedge clk);
        end
        check("t5_wrap_addr", bus.o_mem_addr, 32'h0);
        wait_drain("t5_drain", 40);

        // Misaligned redirect target
        rst_n = 1'b0;
        bus.i_ready = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        bus.i_redirect = 1'b1;
        bus.i_redirect_pc = 32'h11;
`ifdef FETCH_MISALIGN_EN
        @(negedge clk);
        bus.i_redirect = 1'b0;
        check("t6_fault", bus.o_fault, 1);
        check("t6_valid", bus.o_valid, 0);
        check("t6_req", bus.o_mem_req, 0);
        bus.i_ready = 1'b1;
        req_count = 0;
        repeat (10) @(negedge clk);
        check("t6_no_req", req_count, 0);
        check("t6_still_invalid", bus.o_valid, 0);
        check("t6_sticky", bus.o_fault, 1);
`else
        push_exp(32'h10); push_exp(32'h12); push_exp(32'h14);
        @(negedge clk);
        bus.i_redirect = 1'b0;
        check("t6_fault", bus.o_fault, 0);
        check("t6_req", bus.o_mem_req, 1);
        check("t6_addr", bus.o_mem_addr, 32'h10);
        bus.i_ready = 1'b1;
        wait_drain("t6_drain", 40);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not reach the end");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
